// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // A trustworthy comparator answer has exactly one of Lt/Gt/Eq asserted.
    function automatic logic flags_onehot(input logic lt, input logic gt, input logic eq);
        return (lt & ~gt & ~eq) | (~lt & gt & ~eq) | (~lt & ~gt & eq);
    endfunction

endpackage : sar_pkg

// File: rtl/sar_search_if.sv
// Magnitude-compare bus between the search controller (master) and the comparator/requester side (slave).
interface sar_search_if #(
    parameter int WIDTH = sar_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             lt;
    logic             gt;
    logic             eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             error;

    modport master (
        input  start, lt, gt, eq,
        output trial, busy, done, result, found, error
    );

    modport slave (
        output start, lt, gt, eq,
        input  trial, busy, done, result, found, error
    );

endinterface : sar_search_if

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against an external combinational comparator.
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: finish on the first Eq probe instead of always running WIDTH probes.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    sar_search_if.master bus
);

    localparam int IDX_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic             flags_ok;
    logic [WIDTH-1:0] probe_trial;

    assign flags_ok = flags_onehot(bus.lt, bus.gt, bus.eq);

    // Trial after this probe: decide bit idx from Gt, and raise the next lower bit as the new guess.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_probe
        always_comb begin
            probe_trial[gi] = trial_q[gi];
            if (idx_q == IDX_W'(gi)) begin
                probe_trial[gi] = trial_q[gi] & ~bus.gt;
            end else if ((gi < WIDTH - 1) && (idx_q == IDX_W'(gi + 1))) begin
                probe_trial[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_W'(WIDTH - 1);
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        found_d  = found_q;
        error_d  = error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    idx_d              = IDX_W'(WIDTH - 1);
                    found_d            = 1'b0;
                    error_d            = 1'b0;
                    state_d            = PROBE;
                end
            end

            PROBE: begin
                if (!flags_ok) begin
                    // A broken comparator answer invalidates the whole search.
                    error_d  = 1'b1;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = FINISH;
                end else begin
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                    if (bus.eq) begin
                        result_d = trial_q;
                        found_d  = 1'b1;
                        state_d  = FINISH;
                    end else
`endif
                    if (idx_q == '0) begin
                        trial_d  = probe_trial;
                        result_d = probe_trial;
                        found_d  = bus.eq;
                        state_d  = FINISH;
                    end else begin
                        trial_d  = probe_trial;
                        idx_d    = idx_q - 1'b1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.error  = error_q;
    assign bus.busy   = (state_q == PROBE);
    assign bus.done   = (state_q == FINISH);

endmodule : sar_search

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller; the initiator side of the magnitude-compare interface.
- Drives a trial value into an external combinational comparator (Trial on A, hidden target on B) and reads back Lt/Gt/Eq.
- Resolves the target MSB-first in at most WIDTH probe cycles.
- Used wherever a value is reachable only through a comparator, e.g. threshold or ADC-style search.

Parameters:
- WIDTH, 4, bit width of Trial, Result and the searched value (>=2).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- Start  input  1  begin a search; sampled only in IDLE.
- Lt  input  1  comparator result, Trial < target.
- Gt  input  1  comparator result, Trial > target.
- Eq  input  1  comparator result, Trial == target.
- Trial  output  WIDTH  registered value presented to comparator A input.
- Busy  output  1  high in PROBE.
- Done  output  1  one-cycle pulse when the search ends.
- Result  output  WIDTH  final value; held until the next Start is accepted.
- Found  output  1  Eq was seen on the last probe; valid with Done, held with Result.
- Error  output  1  a probe saw Lt/Gt/Eq not one-hot; valid with Done, held.

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE.
  - Trial, Result = 0.
  - Busy, Done, Found, Error = 0.
  - Bit index = WIDTH-1.
- States: IDLE, PROBE, FINISH.
- IDLE, Start=1:
  - Trial <= 1<<(WIDTH-1); idx <= WIDTH-1.
  - Clear Found and Error; go to PROBE.
  - Start=0: stay in IDLE.
- PROBE (one probe per cycle):
  - The comparator is combinational; Lt/Gt/Eq are sampled at the clock edge for the current Trial.
  - Gt: clear Trial[idx].
  - Lt or Eq: keep Trial[idx].
  - If idx==0: next state FINISH.
  - Else: idx <= idx-1 and set Trial[idx-1] in the same update.
- Flags not one-hot (none high, or two or more high):
  - Error <= 1; Result <= 0; go to FINISH immediately.
- FINISH (one cycle):
  - Done=1; Result = resolved Trial; Found = Eq from the last probe.
  - Return to IDLE.
  - Trial holds its final value until the next Start.
- Latency: Start edge to Done high = WIDTH+1 cycles (no early exit).
- Busy is high for exactly the PROBE cycles.
- Start while Busy or in FINISH: ignored, not queued.
- Start in the same cycle Done is high: ignored (state is FINISH). Start is accepted from the following cycle.
- Rst_n asserted mid-search: abort immediately to reset values; no Done pulse.
- Boundaries:
  - Target 0 resolves via all-Gt probes.
  - Target 2^WIDTH-1 resolves via all-Lt probes plus final Eq.
  - No wrap-around is possible; Trial never exceeds 2^WIDTH-1.

Optional Feature:
- Macro SAR_SEARCH_EARLY_EXIT_EN.
- Defined: Eq in any PROBE cycle goes straight to FINISH with Result = current Trial and Found=1. Latency = probes taken + 1.
- Undefined: Eq is treated as "keep bit" and the search always runs WIDTH probes. Found reflects only the last probe.

Decomposition:
- Package sar_pkg:
  - State encoding constants (IDLE=2'd0, PROBE=2'd1, FINISH=2'd2).
  - Default WIDTH constant.
- No RTL sub-module: a single FSM plus datapath is natural.
- The bench instantiates FourBitComparator as the responder model (LtIn=0, GtIn=0, EqIn=1, A=Trial, B=target), WIDTH=4.

Test Plan:
- Target 11, early exit off:
  - Trials 8(Lt), 12(Gt), 10(Lt), 11(Eq).
  - Done at cycle 5 after Start; Result=11, Found=1, Error=0.
- Target 0:
  - Trials 8, 4, 2, 1, all Gt.
  - Result=0, Found=0, Busy high for 4 cycles.
- Target 8, early exit on:
  - First probe Eq; Done 2 cycles after Start; Result=8, Found=1.
  - Same target with early exit off: Result=8 after 4 probes, Found=0 (last probe 9 returns Gt).
- Target 15:
  - Trials 8, 12, 14, 15.
  - Result=15, Found=1.
  - A Start pulse held during Busy does not restart the search.
- Fault on the second probe (Lt=Gt=1):
  - Done on the next cycle; Error=1, Result=0.
  - The next Start clears Error.
- Reset mid-search:
  - Rst_n low during the third probe: all outputs 0 asynchronously.
  - After release, a new Start with target 5 yields Result=5.
